// File: rtl/lsu_if.sv
// Request, response and DataMemory signals of the load/store unit.
// The slave modport is the LSU. The master modport is the requester plus memory side.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_en, mem_rw, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_en, mem_rw, mem_addr, mem_din
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store front end for a word-only DataMemory (sub-word stores via read-modify-write).
// Define LSU_BOUNDS_CHECK_EN to reject word indices >= MEM_WORDS without touching memory.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 32'd21
) (
    input  logic  CLK,
    input  logic  RST_N,
    lsu_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_RD   = 3'd1,
        S_LD_CAP  = 3'd2,
        S_ST_WR   = 3'd3,
        S_RMW_RD  = 3'd4,
        S_RMW_MRG = 3'd5,
        S_RMW_WR  = 3'd6,
        S_RESP    = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        mem_en_s;
    logic        mem_rw_s;
    logic [31:0] mem_addr_s;
    logic [31:0] mem_din_s;

    function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic bad;
        case (f3)
            3'b000:         bad = 1'b0;
            3'b001:         bad = addr[0];
            3'b010:         bad = (addr[1:0] != 2'b00);
            3'b100:         bad = we;
            3'b101:         bad = we | addr[0];
            default:        bad = 1'b1;
        endcase
`ifdef LSU_BOUNDS_CHECK_EN
        bad = bad | ({2'b00, addr[31:2]} >= MEM_WORDS);
`else
        bad = bad | 1'b0;
`endif
        return bad;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] m;
        m = word;
        case (f3)
            3'b000:  m[{off, 3'b000} +: 8] = wd[7:0];
            3'b001:  m[{off[1], 4'b0000} +: 16] = wd[15:0];
            default: m = word;
        endcase
        return m;
    endfunction

    // State and latched request/response registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            merge_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state, request latching, load capture and store merge.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    wdata_d  = bus.req_wdata;
                    if (req_error(bus.req_we, bus.req_funct3, bus.req_addr)) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (!bus.req_we) begin
                        state_d = S_LD_RD;
                    end else if (bus.req_funct3 == 3'b010) begin
                        state_d = S_ST_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LD_RD:  state_d = S_LD_CAP;
            S_LD_CAP: begin
                rdata_d = load_extend(funct3_q, addr_q[1:0], bus.mem_dout);
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_ST_WR: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RMW_RD: state_d = S_RMW_MRG;
            S_RMW_MRG: begin
                merge_d = store_merge(funct3_q, addr_q[1:0], bus.mem_dout, wdata_q);
                state_d = S_RMW_WR;
            end
            S_RMW_WR: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Memory strobes decoded from the registered state and latched fields.
    always_comb begin
        mem_en_s   = 1'b0;
        mem_rw_s   = 1'b0;
        mem_addr_s = 32'd0;
        mem_din_s  = 32'd0;
        case (state_q)
            S_LD_RD, S_RMW_RD: begin
                mem_en_s   = 1'b1;
                mem_addr_s = {2'b00, addr_q[31:2]};
            end
            S_ST_WR: begin
                mem_en_s   = 1'b1;
                mem_rw_s   = we_q;
                mem_addr_s = {2'b00, addr_q[31:2]};
                mem_din_s  = wdata_q;
            end
            S_RMW_WR: begin
                mem_en_s   = 1'b1;
                mem_rw_s   = we_q;
                mem_addr_s = {2'b00, addr_q[31:2]};
                mem_din_s  = merge_q;
            end
            default: begin
                mem_en_s   = 1'b0;
                mem_rw_s   = 1'b0;
                mem_addr_s = 32'd0;
                mem_din_s  = 32'd0;
            end
        endcase
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.mem_en    = mem_en_s;
    assign bus.mem_rw    = mem_rw_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_din   = mem_din_s;

endmodule
